jpeg2bmp_mul_arbiter: RTL
=========================

Name: jpeg2bmp_mul_arbiter

Overview:
- Shares one pipelined 32-bit signed × 10-bit unsigned multiplier among N requesters in the jpeg2bmp datapath, e.g. the IDCT/colour-conversion scaling loops.
- Round-robin arbitration grants at most one request per enabled cycle.
- The granted operands are tagged with the requester index, pushed through a PIPE-deep multiply pipeline, and returned on a shared result bus with a one-hot valid.
- Fixed latency and no result backpressure, so it drops in where HLS-scheduled multiplies are time-multiplexed.

Parameters:
- N, 4, number of requesters (2..8).
- PIPE, 2, multiply latency in ce-enabled cycles from grant to result (1..4).
- DIN0_W, 32, signed operand width.
- DIN1_W, 10, unsigned operand width.
- DOUT_W, 32, result width (product truncated to low DOUT_W bits).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- ce  in  1  global clock enable; 0 freezes the arbiter and the whole pipeline.
- req  in  N  per-requester request; held until granted.
- req_din0  in  N*DIN0_W  packed signed operands; requester i at bits [i*DIN0_W +: DIN0_W].
- req_din1  in  N*DIN1_W  packed unsigned operands, same packing.
- gnt  out  N  one-hot grant, combinational from req, ce and the priority pointer.
- rsp_vld  out  N  one-hot result valid, registered.
- rsp_id  out  clog2(N)  index of the requester owning dout, registered.
- dout  out  DOUT_W  shared result, registered.
- busy  out  1  1 while any pipeline stage holds a valid op.

Behaviour:
- Reset (reset=0, asynchronous), applied immediately regardless of clk/ce:
  - all pipeline valid bits, rsp_vld, rsp_id, dout and busy cleared to 0;
  - priority pointer cleared to 0.
  - gnt stays combinational and is forced to 0 while reset=0.
- Arbitration:
  - gnt[i]=1 iff ce=1, req[i]=1, and i is the first asserted request scanning from the pointer upward with wrap N-1→0.
  - At most one gnt bit is set per cycle.
  - A requester sees the grant in the same cycle and drops or changes req on the next edge.
- Pointer: on an enabled cycle with a grant to k, the pointer becomes (k+1) mod N. No grant or ce=0 leaves it unchanged.
- Capture: on an enabled grant edge, stage 1 latches din0 (signed), din1 (zero-extended), the requester id and valid=1. An enabled cycle with no grant latches valid=0.
- Arithmetic:
  - product = signed(din0) × signed({1'b0,din1});
  - the full DIN0_W+DIN1_W+1 bit product is computed, then the low DOUT_W bits are kept. No saturation.
- Pipeline: stages 1..PIPE advance only when ce=1. The final stage drives dout, rsp_id, and rsp_vld = onehot(id) & valid.
- Latency: the result for a grant in enabled cycle t appears after the edge ending enabled cycle t+PIPE-1, i.e. PIPE enabled edges after grant.
- Throughput: one result per enabled cycle. Results return in grant order.
- Result hold:
  - dout/rsp_id keep their last value when the final stage is invalid; only rsp_vld drops to 0.
  - While ce=0, all outputs hold, including rsp_vld. A consumer must treat a result as delivered once per ce-enabled cycle.
- busy = OR of all stage valid bits.
- Simultaneous requests: all N asserted continuously gives grants pointer, pointer+1, … in strict rotation, each requester once per N cycles.
- A requester that drops req before being granted is simply skipped; no state is retained.
- Reset mid-operation: in-flight ops are discarded with no result emitted after release, and arbitration restarts at requester 0.

Test Plan:
- Reset: reset=0 with req=4'b1111 → gnt=0, rsp_vld=0, dout=0, busy=0. First enabled cycle after release → gnt=4'b0001.
- Single op: req[0], din0=-3, din1=5, ce=1 → gnt=0001 in cycle 0; 2 edges later rsp_vld=0001, rsp_id=0, dout=0xFFFFFFF1 for one cycle; busy high for cycles 1..2.
- Round robin: req=1111 held for 8 cycles, din0=i+1, din1=10 → gnt sequence 0,1,2,3,0,1,2,3; results 10,20,30,40,10,… back-to-back with matching rsp_id.
- Stall: grant req[2] (din0=100, din1=3), then ce=0 for 3 cycles with req[1] asserted → no gnt during stall, outputs frozen, pointer unchanged; rsp_vld=0100, dout=300 arrives 3 cycles late; req[1] is granted on the first enabled cycle.
- Truncation/sign: din0=0x7FFFFFFF, din1=1023 → dout=0x7FFFFC01. din0=0x80000000, din1=1 → dout=0x80000000.
- Reset mid-flight: two ops in flight, pulse reset=0 for 1 cycle asynchronously → rsp_vld/busy drop immediately, no result after release, next grant goes to the lowest asserted requester from index 0.

Source files
------------

// File: rtl/jpeg2bmp_mul_arbiter.sv
// Round-robin arbiter sharing one pipelined signed x unsigned multiplier among N requesters.
// Results return in grant order after PIPE enabled edges, tagged with the requester index.
module jpeg2bmp_mul_arbiter #(
  parameter  int N      = 4,
  parameter  int PIPE   = 2,
  parameter  int DIN0_W = 32,
  parameter  int DIN1_W = 10,
  parameter  int DOUT_W = 32,
  localparam int ID_W   = $clog2(N)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic [N-1:0]          req,
  input  logic [N*DIN0_W-1:0]   req_din0,
  input  logic [N*DIN1_W-1:0]   req_din1,
  output logic [N-1:0]          gnt,
  output logic [N-1:0]          rsp_vld,
  output logic [ID_W-1:0]       rsp_id,
  output logic [DOUT_W-1:0]     dout,
  output logic                  busy
);

  localparam int PROD_W = DIN0_W + DIN1_W + 1;

  logic [ID_W-1:0]   ptr;
  logic              gnt_any;
  logic [ID_W-1:0]   gnt_idx;
  logic [DIN0_W-1:0] sel_d0;
  logic [DIN1_W-1:0] sel_d1;
  int                idx;

  logic [PIPE-1:0]   vld;
  logic [ID_W-1:0]   id_q [PIPE];

  // din1 is zero-extended so the whole product is a single signed multiply
  function automatic logic [DOUT_W-1:0] mul_trunc(input logic [DIN0_W-1:0] a,
                                                  input logic [DIN1_W-1:0] b);
    return DOUT_W'(PROD_W'($signed(a)) * PROD_W'($signed({1'b0, b})));
  endfunction

  always_comb begin
    gnt     = '0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    sel_d0  = '0;
    sel_d1  = '0;
    idx     = 0;
    if (reset && ce) begin
      for (int j = 0; j < N; j++) begin
        idx = (int'(ptr) + j) % N;
        if (!gnt_any && req[idx]) begin
          gnt_any  = 1'b1;
          gnt_idx  = ID_W'(idx);
          gnt[idx] = 1'b1;
          sel_d0   = req_din0[idx*DIN0_W +: DIN0_W];
          sel_d1   = req_din1[idx*DIN1_W +: DIN1_W];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr <= '0;
    end else if (ce && gnt_any) begin
      ptr <= (int'(gnt_idx) == N-1) ? '0 : gnt_idx + ID_W'(1);
    end
  end

  // Valid and id shift together; ids only move with a valid op so rsp_id holds otherwise
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld <= '0;
      for (int s = 0; s < PIPE; s++) id_q[s] <= '0;
    end else if (ce) begin
      vld[0] <= gnt_any;
      if (gnt_any) id_q[0] <= gnt_idx;
      for (int s = 1; s < PIPE; s++) begin
        vld[s] <= vld[s-1];
        if (vld[s-1]) id_q[s] <= id_q[s-1];
      end
    end
  end

  generate
    if (PIPE == 1) begin : g_p1
      logic [DOUT_W-1:0] prod_q;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          prod_q <= '0;
        end else if (ce && gnt_any) begin
          prod_q <= mul_trunc(sel_d0, sel_d1);
        end
      end

      assign dout = prod_q;
    end else begin : g_pn
      logic [DIN0_W-1:0] a_q;
      logic [DIN1_W-1:0] b_q;
      logic [DOUT_W-1:0] prod_q [1:PIPE-1];

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          a_q <= '0;
          b_q <= '0;
          for (int s = 1; s < PIPE; s++) prod_q[s] <= '0;
        end else if (ce) begin
          if (gnt_any) begin
            a_q <= sel_d0;
            b_q <= sel_d1;
          end
          if (vld[0]) prod_q[1] <= mul_trunc(a_q, b_q);
          for (int s = 2; s < PIPE; s++) begin
            if (vld[s-1]) prod_q[s] <= prod_q[s-1];
          end
        end
      end

      assign dout = prod_q[PIPE-1];
    end
  endgenerate

  always_comb begin
    rsp_vld = '0;
    if (vld[PIPE-1]) rsp_vld[id_q[PIPE-1]] = 1'b1;
  end

  assign rsp_id = id_q[PIPE-1];
  assign busy   = |vld;

endmodule
